// File: rtl/reg_file_pkg.sv
// Shared widths and read-source encoding for the architectural register file.
package reg_file_pkg;

  localparam int unsigned REG_N    = 32;
  localparam int unsigned REG_ID_W = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned ROB_W_DEF = 3;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_COMMIT,
    SRC_ROB,
    SRC_REG
  } rd_src_e;

  // x0 is hardwired; any update aimed at it is discarded.
  function automatic logic writes_reg(input logic [REG_ID_W-1:0] id);
    return id != '0;
  endfunction

endpackage

// File: rtl/reg_file_read.sv
// One operand read port: picks value from x0, the committing entry, the ROB, or the register.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned ROB_W = ROB_W_DEF
) (
  input  logic [REG_ID_W-1:0] i_get_id,
  input  logic [XLEN-1:0]     i_reg_val,
  input  logic                i_reg_busy,
  input  logic [ROB_W-1:0]    i_reg_tag,
  input  logic                i_is_commit,
  input  logic [REG_ID_W-1:0] i_set_id,
  input  logic [XLEN-1:0]     i_set_val,
  input  logic [ROB_W-1:0]    i_set_from_rob_id,
  input  logic                i_rob_avail,
  input  logic [XLEN-1:0]     i_rob_val,
  output logic [XLEN-1:0]     o_val,
  output logic                o_has_dep,
  output logic [ROB_W-1:0]    o_dep
);

  rd_src_e w_src;

  always_comb begin
    w_src = SRC_REG;
    if (!writes_reg(i_get_id))
      w_src = SRC_ZERO;
    else if (i_is_commit && i_set_id == i_get_id && i_reg_busy && i_reg_tag == i_set_from_rob_id)
      w_src = SRC_COMMIT;
    else if (i_reg_busy)
      w_src = SRC_ROB;
  end

  always_comb begin
    o_val     = '0;
    o_has_dep = 1'b0;
    o_dep     = '0;
    unique case (w_src)
      SRC_ZERO:   o_val = '0;
      SRC_COMMIT: o_val = i_set_val;
      SRC_ROB: begin
        // ROB answers in the same cycle; only an unresolved tag is reported as pending.
        if (i_rob_avail) begin
          o_val = i_rob_val;
        end else begin
          o_has_dep = 1'b1;
          o_dep     = i_reg_tag;
        end
      end
      SRC_REG:    o_val = i_reg_val;
      default:    o_val = '0;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags, commit bypass and same-cycle ROB forwarding.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned ROB_W = ROB_W_DEF
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rob_clear,
  input  logic                is_commit,
  input  logic [REG_ID_W-1:0] set_id,
  input  logic [XLEN-1:0]     set_val,
  input  logic [ROB_W-1:0]    set_from_rob_id,
  input  logic [REG_ID_W-1:0] set_dep_id,
  input  logic [ROB_W-1:0]    set_dep_Q,
  input  logic [REG_ID_W-1:0] get_id_1,
  input  logic [REG_ID_W-1:0] get_id_2,
  output logic [XLEN-1:0]     val_1,
  output logic [XLEN-1:0]     val_2,
  output logic                has_dep_1,
  output logic                has_dep_2,
  output logic [ROB_W-1:0]    dep_1,
  output logic [ROB_W-1:0]    dep_2,
  output logic [ROB_W-1:0]    get_rob_id_1,
  output logic [ROB_W-1:0]    get_rob_id_2,
  input  logic                rob_avail_1,
  input  logic                rob_avail_2,
  input  logic [XLEN-1:0]     rob_val_1,
  input  logic [XLEN-1:0]     rob_val_2
);

  logic [XLEN-1:0]  r_val  [REG_N];
  logic             r_busy [REG_N];
  logic [ROB_W-1:0] r_tag  [REG_N];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        r_val[i[REG_ID_W-1:0]]  <= '0;
        r_busy[i[REG_ID_W-1:0]] <= 1'b0;
        r_tag[i[REG_ID_W-1:0]]  <= '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int unsigned i = 0; i < REG_N; i++) begin
          r_busy[i[REG_ID_W-1:0]] <= 1'b0;
          r_tag[i[REG_ID_W-1:0]]  <= '0;
        end
      end else begin
        if (is_commit && writes_reg(set_id)) begin
          r_val[set_id] <= set_val;
          if (r_busy[set_id] && r_tag[set_id] == set_from_rob_id)
            r_busy[set_id] <= 1'b0;
        end
        // Placed after the commit so a same-cycle rename of that register wins.
        if (writes_reg(set_dep_id)) begin
          r_busy[set_dep_id] <= 1'b1;
          r_tag[set_dep_id]  <= set_dep_Q;
        end
      end
    end
  end

  assign get_rob_id_1 = r_tag[get_id_1];
  assign get_rob_id_2 = r_tag[get_id_2];

  reg_read_port #(.ROB_W(ROB_W)) u_port1 (
    .i_get_id          (get_id_1),
    .i_reg_val         (r_val[get_id_1]),
    .i_reg_busy        (r_busy[get_id_1]),
    .i_reg_tag         (r_tag[get_id_1]),
    .i_is_commit       (is_commit),
    .i_set_id          (set_id),
    .i_set_val         (set_val),
    .i_set_from_rob_id (set_from_rob_id),
    .i_rob_avail       (rob_avail_1),
    .i_rob_val         (rob_val_1),
    .o_val             (val_1),
    .o_has_dep         (has_dep_1),
    .o_dep             (dep_1)
  );

  reg_read_port #(.ROB_W(ROB_W)) u_port2 (
    .i_get_id          (get_id_2),
    .i_reg_val         (r_val[get_id_2]),
    .i_reg_busy        (r_busy[get_id_2]),
    .i_reg_tag         (r_tag[get_id_2]),
    .i_is_commit       (is_commit),
    .i_set_id          (set_id),
    .i_set_val         (set_val),
    .i_set_from_rob_id (set_from_rob_id),
    .i_rob_avail       (rob_avail_2),
    .i_rob_val         (rob_val_2),
    .o_val             (val_2),
    .o_has_dep         (has_dep_2),
    .o_dep             (dep_2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file;

  localparam int unsigned RW = 3;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          rob_clear;
  logic          is_commit;
  logic [4:0]    set_id;
  logic [31:0]   set_val;
  logic [RW-1:0] set_from_rob_id;
  logic [4:0]    set_dep_id;
  logic [RW-1:0] set_dep_Q;
  logic [4:0]    get_id_1, get_id_2;
  logic [31:0]   val_1, val_2;
  logic          has_dep_1, has_dep_2;
  logic [RW-1:0] dep_1, dep_2;
  logic [RW-1:0] get_rob_id_1, get_rob_id_2;
  logic          rob_avail_1, rob_avail_2;
  logic [31:0]   rob_val_1, rob_val_2;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  reg_file #(.ROB_W(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .is_commit(is_commit), .set_id(set_id), .set_val(set_val),
    .set_from_rob_id(set_from_rob_id), .set_dep_id(set_dep_id), .set_dep_Q(set_dep_Q),
    .get_id_1(get_id_1), .get_id_2(get_id_2),
    .val_1(val_1), .val_2(val_2), .has_dep_1(has_dep_1), .has_dep_2(has_dep_2),
    .dep_1(dep_1), .dep_2(dep_2), .get_rob_id_1(get_rob_id_1), .get_rob_id_2(get_rob_id_2),
    .rob_avail_1(rob_avail_1), .rob_avail_2(rob_avail_2),
    .rob_val_1(rob_val_1), .rob_val_2(rob_val_2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference architectural state: reset clears everything, then spec update rules per edge.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else begin
        if (is_commit && set_id != 0) begin
          m_val[set_id] = set_val;
          if (m_busy[set_id] && m_tag[set_id] == set_from_rob_id) m_busy[set_id] = 1'b0;
        end
        if (set_dep_id != 0) begin
          m_busy[set_dep_id] = 1'b1;
          m_tag[set_dep_id]  = set_dep_Q;
        end
      end
    end
  end

  function automatic void expect_port(input logic [4:0] id, input logic avail, input logic [31:0] rv,
                                      output logic [31:0] ev, output logic eh,
                                      output logic [RW-1:0] ed, output logic [RW-1:0] eg);
    ev = '0; eh = 1'b0; ed = '0; eg = m_tag[id];
    if (id == 0) ev = '0;
    else if (is_commit && set_id == id && m_busy[id] && m_tag[id] == set_from_rob_id) ev = set_val;
    else if (m_busy[id] && avail) ev = rv;
    else if (m_busy[id]) begin eh = 1'b1; ed = m_tag[id]; end
    else ev = m_val[id];
  endfunction

  always @(negedge clk_in) begin
    logic [31:0] ev; logic eh; logic [RW-1:0] ed, eg;
    if (chk_en) begin
      expect_port(get_id_1, rob_avail_1, rob_val_1, ev, eh, ed, eg);
      chk("val_1", val_1, ev);
      chk("has_dep_1", 32'(has_dep_1), 32'(eh));
      chk("dep_1", 32'(dep_1), 32'(ed));
      chk("get_rob_id_1", 32'(get_rob_id_1), 32'(eg));
      expect_port(get_id_2, rob_avail_2, rob_val_2, ev, eh, ed, eg);
      chk("val_2", val_2, ev);
      chk("has_dep_2", 32'(has_dep_2), 32'(eh));
      chk("dep_2", 32'(dep_2), 32'(ed));
      chk("get_rob_id_2", 32'(get_rob_id_2), 32'(eg));
    end
  end

  task automatic idle();
    rdy_in = 1'b1; rob_clear = 1'b0; is_commit = 1'b0;
    set_id = '0; set_val = '0; set_from_rob_id = '0; set_dep_id = '0; set_dep_Q = '0;
    get_id_1 = '0; get_id_2 = '0;
    rob_avail_1 = 1'b0; rob_avail_2 = 1'b0; rob_val_1 = '0; rob_val_2 = '0;
  endtask

  task automatic next();
    @(posedge clk_in); #1; idle();
  endtask

  task automatic rename(input logic [4:0] r, input logic [RW-1:0] q);
    set_dep_id = r; set_dep_Q = q; next();
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] v, input logic [RW-1:0] t);
    is_commit = 1'b1; set_id = r; set_val = v; set_from_rob_id = t; next();
  endtask

  initial begin
    rst_in = 1'b1; idle();
    chk_en = 1'b1;
    @(negedge clk_in);
    chk("rst_val_1", val_1, 32'h0);
    chk("rst_has_dep_1", 32'(has_dep_1), 32'h0);
    chk("rst_get_rob_id_2", 32'(get_rob_id_2), 32'h0);
    @(posedge clk_in); #1; rst_in = 1'b0;

    // Rename then commit on x5
    rename(5'd5, 3'd4);
    get_id_1 = 5'd5;
    @(negedge clk_in);
    chk("ren_has_dep", 32'(has_dep_1), 32'h1);
    chk("ren_dep", 32'(dep_1), 32'h4);
    next();
    get_id_1 = 5'd5; is_commit = 1'b1; set_id = 5'd5; set_val = 32'hDEADBEEF; set_from_rob_id = 3'd4;
    @(negedge clk_in);
    chk("bypass_val", val_1, 32'hDEADBEEF);
    chk("bypass_has_dep", 32'(has_dep_1), 32'h0);
    next();
    get_id_1 = 5'd5;
    @(negedge clk_in);
    chk("post_commit_val", val_1, 32'hDEADBEEF);
    chk("post_commit_has_dep", 32'(has_dep_1), 32'h0);
    next();

    // Stale commit on x7
    rename(5'd7, 3'd1);
    rename(5'd7, 3'd6);
    commit(5'd7, 32'h1234, 3'd1);
    get_id_1 = 5'd7;
    @(negedge clk_in);
    chk("stale_has_dep", 32'(has_dep_1), 32'h1);
    chk("stale_dep", 32'(dep_1), 32'h6);
    next();

    // ROB forward on x9
    rename(5'd9, 3'd3);
    get_id_2 = 5'd9; rob_avail_2 = 1'b1; rob_val_2 = 32'h55;
    @(negedge clk_in);
    chk("fwd_val", val_2, 32'h55);
    chk("fwd_has_dep", 32'(has_dep_2), 32'h0);
    chk("fwd_rob_id", 32'(get_rob_id_2), 32'h3);
    next();

    // Same-cycle commit and rename on x10
    rename(5'd10, 3'd2);
    is_commit = 1'b1; set_id = 5'd10; set_val = 32'hA5A5A5A5; set_from_rob_id = 3'd2;
    set_dep_id = 5'd10; set_dep_Q = 3'd5;
    next();
    get_id_1 = 5'd10;
    @(negedge clk_in);
    chk("same_has_dep", 32'(has_dep_1), 32'h1);
    chk("same_dep", 32'(dep_1), 32'h5);
    next();

    // Flush with a coincident wrong-path commit to x1
    commit(5'd1, 32'h11, 3'd0);
    rename(5'd1, 3'd1);
    rename(5'd2, 3'd2);
    rename(5'd31, 3'd7);
    rob_clear = 1'b1; is_commit = 1'b1; set_id = 5'd1; set_val = 32'h77; set_from_rob_id = 3'd1;
    next();
    get_id_1 = 5'd1; get_id_2 = 5'd31;
    @(negedge clk_in);
    chk("flush_x1_val", val_1, 32'h11);
    chk("flush_x1_has_dep", 32'(has_dep_1), 32'h0);
    chk("flush_x31_has_dep", 32'(has_dep_2), 32'h0);
    next();
    get_id_1 = 5'd10; get_id_2 = 5'd7;
    @(negedge clk_in);
    chk("flush_x10_val", val_1, 32'hA5A5A5A5);
    chk("flush_x7_val", val_2, 32'h1234);
    next();

    // x0 ignores commit and rename
    is_commit = 1'b1; set_id = 5'd0; set_val = 32'hFF; set_dep_id = 5'd0; set_dep_Q = 3'd3;
    next();
    get_id_1 = 5'd0;
    @(negedge clk_in);
    chk("x0_val", val_1, 32'h0);
    chk("x0_has_dep", 32'(has_dep_1), 32'h0);
    chk("x0_rob_id", 32'(get_rob_id_1), 32'h0);
    next();

    // Asynchronous reset with x3 busy, checked before any clock edge
    rename(5'd3, 3'd2);
    get_id_1 = 5'd3;
    #2 rst_in = 1'b1;
    #1;
    chk("arst_val", val_1, 32'h0);
    chk("arst_has_dep", 32'(has_dep_1), 32'h0);
    chk("arst_rob_id", 32'(get_rob_id_1), 32'h0);
    next();
    next();
    rst_in = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rdy_in          = ($urandom_range(0, 9) != 0);
      rob_clear       = ($urandom_range(0, 29) == 0);
      is_commit       = 1'($urandom_range(0, 1));
      set_id          = 5'($urandom_range(0, 31));
      set_val         = $urandom;
      set_from_rob_id = ($urandom_range(0, 1) != 0) ? m_tag[set_id] : RW'($urandom_range(0, 7));
      set_dep_id      = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      set_dep_Q       = RW'($urandom_range(0, 7));
      get_id_1        = ($urandom_range(0, 3) == 0) ? set_id : 5'($urandom_range(0, 31));
      get_id_2        = 5'($urandom_range(0, 31));
      rob_avail_1     = 1'($urandom_range(0, 1));
      rob_avail_2     = 1'($urandom_range(0, 1));
      rob_val_1       = $urandom;
      rob_val_2       = $urandom;
      @(posedge clk_in); #1;
    end

    idle();
    @(negedge clk_in);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with per-register rename tags for the out-of-order core. It sits between decode/issue and the reorder buffer. It takes commits and dependency (rename) updates from the reorder buffer and gives the decoder two operands, each as either a ready value or a pending ROB tag. Unresolved tags are looked up in the ROB in the same cycle, so results already written back are forwarded without waiting for commit.

## Interface
Parameters:
- ROB_W, default 3: ROB index width; must equal the width of `ROB_R in const.v.

Ports:
- clk_in  in  1  clock; all state updates on posedge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; when low, all state holds.
- rob_clear  in  1  misprediction flush from ROB.
- is_commit  in  1  ROB head commits this cycle.
- set_id  in  5  committed destination; 0 means no register write.
- set_val  in  32  committed value.
- set_from_rob_id  in  ROB_W  ROB index of the committing entry.
- set_dep_id  in  5  register renamed by the issuing instruction; 0 means none.
- set_dep_Q  in  ROB_W  ROB index that now produces set_dep_id.
- get_id_1 / get_id_2  in  5  decoder source registers rs1 / rs2.
- val_1 / val_2  out  32  operand value, valid when has_dep_k = 0.
- has_dep_1 / has_dep_2  out  1  operand still pending.
- dep_1 / dep_2  out  ROB_W  ROB tag to wait on; 0 when there is no dependency.
- get_rob_id_1 / get_rob_id_2  out  ROB_W  tag sent to the ROB for lookup.
- rob_avail_1 / rob_avail_2  in  1  ROB reports that the result for the tag is ready.
- rob_val_1 / rob_val_2  in  32  ROB value for the tag.

## Operation
Per-register state for x0..x31: val[31:0], busy, tag[ROB_W-1:0].
- x0 reads 0 and is never busy. Writes and renames targeting x0 are dropped.

Sequential update, on posedge with rdy_in = 1:
- rob_clear = 1: all busy and tag cleared to 0; val retained. is_commit and set_dep are ignored in that cycle, because they belong to the wrong path.
- Otherwise, commit with set_id ≠ 0: val[set_id] <= set_val.
  - If busy[set_id] and tag[set_id] == set_from_rob_id, busy[set_id] <= 0.
  - If the tag differs, a younger producer owns the register and busy/tag are untouched.
- Otherwise, rename with set_dep_id ≠ 0: busy <= 1, tag <= set_dep_Q.
  - A rename in the same cycle as a commit to the same register wins: busy stays 1 and tag takes the new value, while val still takes set_val.

Combinational read, per port k:
- get_rob_id_k = tag[get_id_k].
- get_id_k = 0: val_k = 0, has_dep_k = 0.
- Commit bypass: is_commit, set_id == get_id_k, busy, and tag == set_from_rob_id. Output val_k = set_val, has_dep_k = 0.
- Busy and rob_avail_k: val_k = rob_val_k, has_dep_k = 0.
- Busy and not rob_avail_k: has_dep_k = 1, dep_k = tag, val_k = 0.
- Not busy: val_k = val[get_id_k], has_dep_k = 0.
- dep_k = 0 whenever has_dep_k = 0.
- Reads see state from before the same-cycle rename. An instruction's own rd rename therefore never aliases its own rs1/rs2, e.g. add x5, x5, x1 reads the old x5 producer.

Reset:
- Asynchronous: all val, busy and tag go to 0 immediately, regardless of rdy_in or the clock.
- With no active lookup, all outputs read as 0.
- Reset mid-operation discards any pending renames.

## Timing
- Read path: 0-cycle latency, purely combinational from get_id_k, commit inputs and ROB lookup inputs.
- Commit and rename: visible on the read ports in the cycle after the posedge. The commit bypass covers the commit cycle itself.
- Flush: busy is clear from the cycle after rob_clear is sampled high.
- The ROB lookup path has no registers; the ROB answers in the same cycle.

## Structure
- const.v holds the shared macros: `ROB_R, `ROB_A, and a register-count macro `REG_N = 32.
- One sub-module, reg_read_port, instantiated twice. It contains the per-port forwarding priority mux and takes the selected register's val, busy and tag plus the commit and ROB lookup inputs.
- The top level holds the state arrays and the update logic.

## Test plan
- Reset: assert rst_in mid-run with x3 busy (tag 2). x3 then reads val 0 with has_dep 0, and reset takes effect without a clock edge.
- Rename then commit:
  - Rename x5 → tag 4. Next cycle get_id_1 = 5 gives has_dep_1 = 1, dep_1 = 4.
  - Commit set_id = 5, set_val = 0xDEADBEEF, rob_id 4 gives val_1 = 0xDEADBEEF, has_dep_1 = 0 in the same cycle, and busy is clear afterwards.
- Stale commit: x7 renamed to tag 1, then to tag 6. Commit of rob_id 1 writes val, but x7 stays busy with tag 6.
- ROB forward: x9 busy with tag 3, rob_avail_2 = 1, rob_val_2 = 0x55 gives val_2 = 0x55, has_dep_2 = 0.
- Same-cycle commit and rename on x10 (commit tag 2, new tag 5): next cycle x10 is busy with tag 5 and val = committed value.
- Flush: x1, x2 and x31 busy, rob_clear = 1 with a coincident commit to x1 (0x77). Afterwards none are busy and x1 keeps its old value; x0 always reads 0 even after a commit or rename targeting it.
